// File: rtl/matmul_seq.sv
// Sequencer for the 4x4 systolic matmul array.
// Runs one job per command: a clear cycle, K accumulate beats, a four-cycle drain
// that captures the array's rotating result rows, then streams rows 0..3 out.
// Optional: define MATMUL_SEQ_RELU_EN to clamp negative output lanes to zero.
module matmul_seq #(
    parameter int unsigned N  = 4,
    parameter int unsigned L  = 16,
    parameter int unsigned KW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [KW-1:0]   cmd_k,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*L-1:0]  in_a,
    input  logic [N*L-1:0]  in_b,
    output logic [1:0]      mm_op,
    output logic [N*L-1:0]  mm_a,
    output logic [N*L-1:0]  mm_b,
    input  logic [N*L-1:0]  mm_c,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*L-1:0]  out_data,
    output logic [1:0]      out_row,
    output logic            out_last,
    output logic            busy
);

    localparam logic [1:0] LastRow = 2'(N - 1);

    typedef enum logic [2:0] {StIdle, StClear, StLoad, StDrain, StOut} state_e;

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [KW-1:0]    beat_q, beat_d;
    logic [1:0]       drain_q, drain_d;
    logic [1:0]       out_row_q, out_row_d;
    logic [1:0]       tick_q, tick_d;
    logic [N*L-1:0]   rowbuf_q [N];
    logic [N*L-1:0]   rowbuf_d [N];
    logic [N*L-1:0]   row_sel;

    // Next-state, handshake and array-op decode
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        beat_d    = beat_q;
        drain_d   = drain_q;
        out_row_d = out_row_q;
        rowbuf_d  = rowbuf_q;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        mm_op     = 2'b00;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    k_d     = cmd_k;
                    state_d = StClear;
                end
            end
            StClear: begin
                mm_op   = 2'b01;
                beat_d  = '0;
                state_d = (k_q != '0) ? StLoad : StDrain;
            end
            StLoad: begin
                in_ready = 1'b1;
                // Bubbles issue op=00, which leaves the accumulators untouched
                if (in_valid) begin
                    mm_op  = 2'b10;
                    beat_d = beat_q + KW'(1);
                    if (beat_q == k_q - KW'(1)) begin
                        beat_d  = '0;
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // The array presents row[tick] each cycle; four cycles cover every row
                rowbuf_d[tick_q] = mm_c;
                drain_d          = drain_q + 2'd1;
                if (drain_q == LastRow) begin
                    drain_d = '0;
                    state_d = StOut;
                end
            end
            StOut: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    out_row_d = out_row_q + 2'd1;
                    if (out_row_q == LastRow) begin
                        out_row_d = '0;
                        state_d   = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Mirror of the array's row select: parks at the last row on clear, else rotates
    always_comb begin
        tick_d = mm_op[0] ? LastRow : tick_q + 2'd1;
    end

    // Output row selection with optional negative-lane clamp
    always_comb begin
        row_sel  = rowbuf_q[out_row_q];
        out_data = row_sel;
`ifdef MATMUL_SEQ_RELU_EN
        for (int unsigned j = 0; j < N; j++) begin
            if (row_sel[j*L + L - 1]) out_data[j*L +: L] = '0;
        end
`endif
    end

    assign mm_a     = (mm_op == 2'b10) ? in_a : '0;
    assign mm_b     = (mm_op == 2'b10) ? in_b : '0;
    assign out_row  = out_row_q;
    assign out_last = out_valid && (out_row_q == LastRow);
    assign busy     = (state_q != StIdle);

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            k_q       <= '0;
            beat_q    <= '0;
            drain_q   <= '0;
            out_row_q <= '0;
            tick_q    <= LastRow;
            rowbuf_q  <= '{default: '0};
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            beat_q    <= beat_d;
            drain_q   <= drain_d;
            out_row_q <= out_row_d;
            tick_q    <= tick_d;
            rowbuf_q  <= rowbuf_d;
        end
    end

endmodule

// File: tb/tb_matmul_seq.sv
// Bench for matmul_seq: includes a behavioural 4x4 array model on the mm_* ports,
// a scoreboard filled on command accept and a monitor checking the output stream.
module tb_matmul_seq;

    localparam int N  = 4;
    localparam int L  = 16;
    localparam int KW = 8;
    localparam int W  = N * L;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [KW-1:0] cmd_k = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [1:0]    mm_op;
    logic [W-1:0]  mm_a;
    logic [W-1:0]  mm_b;
    logic [W-1:0]  mm_c;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic [1:0]    out_row;
    logic          out_last;
    logic          busy;

    always #5 clk = ~clk;

    matmul_seq #(.N(N), .L(L), .KW(KW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_k     (cmd_k),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mm_op     (mm_op),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_c      (mm_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int accept_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Array model: clear on rst/op[0], accumulate outer product on op[1], c = row[tick]
    logic [L-1:0] acc [N][N];
    logic [1:0]   atick;

    always @(posedge clk) begin
        if (rst || mm_op[0]) begin
            atick <= 2'd3;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) acc[i][j] <= '0;
        end else begin
            atick <= atick + 2'd1;
            if (mm_op[1])
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        acc[i][j] <= acc[i][j] + mm_a[i*L +: L] * mm_b[j*L +: L];
        end
    end

    always_comb begin
        mm_c = '0;
        for (int j = 0; j < N; j++) mm_c[j*L +: L] = acc[atick][j];
    end

    // Beats of the job about to be (or being) commanded
    logic [W-1:0] ja[$];
    logic [W-1:0] jb[$];

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   row;
        logic         last;
    } exp_t;
    exp_t exp_q[$];

    // Reference: C = A*B with wrapping lanes, optional clamp
    function automatic void push_job(input int k);
        for (int r = 0; r < N; r++) begin
            exp_t e;
            e.data = '0;
            for (int j = 0; j < N; j++) begin
                longint       s = 0;
                logic [L-1:0] lane;
                for (int t = 0; t < k && t < ja.size(); t++) begin
                    logic [W-1:0] va;
                    logic [W-1:0] vb;
                    va = ja[t];
                    vb = jb[t];
                    s += longint'($signed(va[r*L +: L])) * longint'($signed(vb[j*L +: L]));
                end
                lane = s[L-1:0];
`ifdef MATMUL_SEQ_RELU_EN
                if (lane[L-1]) lane = '0;
`endif
                e.data[j*L +: L] = lane;
            end
            e.row  = 2'(r);
            e.last = (r == N - 1);
            exp_q.push_back(e);
        end
    endfunction

    // Scoreboard fill on accept; monitor checks output rows and backpressure hold
    logic         hold_prev = 1'b0;
    logic         rst_prev  = 1'b1;
    logic [W-1:0] data_prev = '0;
    logic [1:0]   row_prev  = '0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (cmd_valid && cmd_ready) push_job(int'(cmd_k));
            if (hold_prev && !rst_prev) begin
                check("hold_valid", W'(out_valid), W'(1'b1));
                check("hold_data", out_data, data_prev);
                check("hold_row", W'(out_row), W'(row_prev));
            end
            if (out_valid && out_ready) begin
                check("row_expected", W'(exp_q.size() != 0), W'(1'b1));
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_row", W'(out_row), W'(e.row));
                    check("out_last", W'(out_last), W'(e.last));
                end
            end
        end
        hold_prev <= out_valid && !out_ready;
        rst_prev  <= rst;
        data_prev <= out_data;
        row_prev  <= out_row;
    end

    // out_ready driver: 0 = always ready, 1 = random, 2 = forced value
    int   ready_mode  = 0;
    logic ready_force = 1'b1;

    always @(posedge clk) begin
        #2;
        if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
        else if (ready_mode == 2) out_ready = ready_force;
        else out_ready = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    task automatic issue(input int k);
        int n;
        bit ok;
        n  = 0;
        ok = 0;
        cmd_k     = KW'(k);
        cmd_valid = 1'b1;
        while (n < 400) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                accept_cyc = cyc;
                break;
            end
            n++;
        end
        check("cmd_accept_timeout", W'(ok), W'(1'b1));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic feed(input bit bubbles, input int nb);
        for (int b = 0; b < nb; b++) begin
            int n;
            bit ok;
            if (bubbles) begin
                in_valid = 1'b0;
                in_a = {$urandom, $urandom};
                in_b = {$urandom, $urandom};
                @(negedge clk);
                if (in_ready) begin
                    check("bubble_op", W'(mm_op), W'(2'b00));
                    check("bubble_a", mm_a, '0);
                    check("bubble_busy", W'(busy), W'(1'b1));
                end
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_a = ja[b];
            in_b = jb[b];
            n  = 0;
            ok = 0;
            while (n < 50) begin
                @(negedge clk);
                if (in_ready) begin
                    ok = 1;
                    break;
                end
                check("no_consume_op", W'(mm_op == 2'b10), W'(1'b0));
                n++;
            end
            check("beat_timeout", W'(ok), W'(1'b1));
            check("beat_op", W'(mm_op), W'(2'b10));
            check("beat_a", mm_a, in_a);
            check("beat_b", mm_b, in_b);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
        end
        check("out_valid_timeout", W'(out_valid), W'(1'b1));
    endtask

    task automatic wait_done();
        int n;
        bit ok;
        n  = 0;
        ok = 0;
        while (n < 400) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
            n++;
        end
        check("job_done_timeout", W'(ok), W'(1'b1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] v;
        int           k;
        bit           seen_ready;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", W'(cmd_ready), W'(1'b1));
        check("rst_in_ready", W'(in_ready), W'(1'b0));
        check("rst_mm_op", W'(mm_op), W'(2'b00));
        check("rst_out_valid", W'(out_valid), W'(1'b0));
        check("rst_out_row", W'(out_row), W'(2'b00));
        check("rst_out_last", W'(out_last), W'(1'b0));
        check("rst_busy", W'(busy), W'(1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Identity: A = I via unit columns, B rows 1..16
        ja.delete();
        jb.delete();
        for (int t = 0; t < N; t++) begin
            v = '0;
            v[t*L +: L] = 16'd1;
            ja.push_back(v);
            v = '0;
            for (int j = 0; j < N; j++) v[j*L +: L] = 16'(4 * t + j + 1);
            jb.push_back(v);
        end
        issue(4);
        feed(1'b0, 4);
        wait_out();
        check("latency_k4", W'(cyc - accept_cyc), W'(10));
        check("first_row_idx", W'(out_row), W'(2'b00));
        wait_done();

        // Same job with bubbles between beats
        issue(4);
        feed(1'b1, 4);
        wait_done();

        // K = 0: no beats consumed, all-zero rows
        ja.delete();
        jb.delete();
        issue(0);
        in_valid   = 1'b1;
        in_a       = {$urandom, $urandom};
        in_b       = {$urandom, $urandom};
        seen_ready = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready) seen_ready = 1;
            if (out_valid) break;
        end
        check("k0_no_in_ready", W'(seen_ready), W'(1'b0));
        check("k0_out_valid", W'(out_valid), W'(1'b1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done();

        // Backpressure on row 1 with a second command held
        ja.delete();
        jb.delete();
        for (int t = 0; t < 3; t++) begin
            ja.push_back({$urandom, $urandom});
            jb.push_back({$urandom, $urandom});
        end
        ready_mode  = 2;
        ready_force = 1'b0;
        issue(3);
        feed(1'b0, 3);
        ja.delete();
        jb.delete();
        cmd_k     = '0;
        cmd_valid = 1'b1;
        wait_out();
        check("held_cmd_ready_row0", W'(cmd_ready), W'(1'b0));
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        @(posedge clk);
        #1;
        ready_force = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("bp_row1_idx", W'(out_row), W'(2'b01));
            check("bp_cmd_ready", W'(cmd_ready), W'(1'b0));
            @(posedge clk);
            #1;
        end
        ready_mode = 0;
        issue(0);
        wait_done();

        // Wrap and negative products
        ja.delete();
        jb.delete();
        v = '0;
        v[0 +: L] = 16'h7FFF;
        v[L +: L] = 16'd3;
        ja.push_back(v);
        v = '0;
        v[0 +: L] = 16'd2;
        v[L +: L] = 16'hFFFE;
        jb.push_back(v);
        issue(1);
        feed(1'b0, 1);
        wait_out();
        v = out_data;
`ifdef MATMUL_SEQ_RELU_EN
        check("wrap_lane", W'(v[0 +: L]), W'(16'h0000));
`else
        check("wrap_lane", W'(v[0 +: L]), W'(16'hFFFE));
`endif
        @(posedge clk);
        #1;
        @(negedge clk);
        v = out_data;
        check("neg_row_idx", W'(out_row), W'(2'b01));
`ifdef MATMUL_SEQ_RELU_EN
        check("neg_lane", W'(v[L +: L]), W'(16'h0000));
`else
        check("neg_lane", W'(v[L +: L]), W'(16'hFFFA));
`endif
        wait_done();

        // Reset mid-LOAD after two of four beats
        ja.delete();
        jb.delete();
        for (int t = 0; t < 4; t++) begin
            ja.push_back({$urandom, $urandom});
            jb.push_back({$urandom, $urandom});
        end
        issue(4);
        feed(1'b0, 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", W'(out_valid), W'(1'b0));
        check("abort_mm_op", W'(mm_op), W'(2'b00));
        check("abort_busy", W'(busy), W'(1'b0));
        check("abort_cmd_ready", W'(cmd_ready), W'(1'b1));
        @(posedge clk);
        #1;
        ja.delete();
        jb.delete();
        v = '0;
        for (int j = 0; j < N; j++) v[j*L +: L] = 16'd1;
        ja.push_back(v);
        jb.push_back(v);
        issue(1);
        feed(1'b0, 1);
        wait_done();

        // Random jobs with random bubbles and backpressure
        ready_mode = 1;
        for (int r = 0; r < 8; r++) begin
            k = int'($urandom_range(0, 6));
            ja.delete();
            jb.delete();
            for (int t = 0; t < k; t++) begin
                ja.push_back({$urandom, $urandom});
                jb.push_back({$urandom, $urandom});
            end
            issue(k);
            feed(1'($urandom_range(0, 1)), k);
            wait_done();
        end
        ready_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
